// File: rtl/adc_arb_pkg.sv
// Shared types and constants for the ADC sharing arbiter.
// Channel numbers match the slide-pot scanner's ADC channel map.
package adc_arb_pkg;

   localparam int CHNL_W = 3;
   localparam int RES_W  = 12;
   localparam int IDX_W  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_e;

   localparam logic [CHNL_W-1:0] LP     = 3'd0;
   localparam logic [CHNL_W-1:0] B1     = 3'd1;
   localparam logic [CHNL_W-1:0] B2     = 3'd2;
   localparam logic [CHNL_W-1:0] B3     = 3'd3;
   localparam logic [CHNL_W-1:0] HP     = 3'd4;
   localparam logic [CHNL_W-1:0] VOLUME = 3'd7;

endpackage

// File: rtl/adc_share_arb_rr_pick.sv
// Combinational round-robin select: first set request after 'last', with wrap.
module rr_pick
   import adc_arb_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] pick,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   int  pos;
   logic found;

   assign any = |req;

   // Walk the requesters starting one past the last winner; first hit wins.
   always_comb begin
      pick  = '0;
      idx   = '0;
      pos   = 0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = (int'(last) + 1 + k) % NUM_REQ;
         if (!found && req[pos]) begin
            found     = 1'b1;
            pick[pos] = 1'b1;
            idx       = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/adc_share_arb.sv
// Shares one ADC conversion interface between NUM_REQ requesters in round-robin
// order, routing the result back and aborting conversions the ADC never finishes.
module adc_share_arb
   import adc_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int TIMEOUT = 4096
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [CHNL_W*NUM_REQ-1:0] req_chnnl,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic                      err,
   output logic [RES_W-1:0]          rd_data,
   output logic                      strt_cnv,
   output logic [CHNL_W-1:0]         chnnl,
   input  logic [RES_W-1:0]          res,
   input  logic                      cnv_cmplt
);

   localparam int              TW   = $clog2(TIMEOUT);
   localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT - 1);

   if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
      $error("adc_share_arb: NUM_REQ must be in 2..4");
   end
   if (TIMEOUT < 4) begin : g_bad_timeout
      $error("adc_share_arb: TIMEOUT must be at least 4");
   end

   arb_state_e          state, state_nxt;
   logic [NUM_REQ-1:0]  gnt_nxt, done_nxt;
   logic                err_nxt, strt_nxt;
   logic [RES_W-1:0]    rd_nxt;
   logic [CHNL_W-1:0]   chnnl_nxt, chn_sel;
   logic [IDX_W-1:0]    last, last_nxt, gidx, gidx_nxt;
   logic [TW-1:0]       tcnt, tcnt_nxt;

   logic [NUM_REQ-1:0]  pick;
   logic [IDX_W-1:0]    pick_idx;
   logic                any;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req  (req),
      .last (last),
      .pick (pick),
      .idx  (pick_idx),
      .any  (any)
   );

   always_comb begin
      chn_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) chn_sel = req_chnnl[i*CHNL_W +: CHNL_W];
      end
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      done_nxt  = '0;
      err_nxt   = err;
      rd_nxt    = rd_data;
      strt_nxt  = 1'b0;
      chnnl_nxt = chnnl;
      last_nxt  = last;
      gidx_nxt  = gidx;
      tcnt_nxt  = tcnt;
      case (state)
         IDLE: begin
            if (any) begin
               gnt_nxt   = pick;
               chnnl_nxt = chn_sel;
               gidx_nxt  = pick_idx;
               strt_nxt  = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            tcnt_nxt  = '0;
            state_nxt = WAIT;
         end
         WAIT: begin
            tcnt_nxt = tcnt + 1'b1;
            // A real result always beats the timeout when both land together.
            if (cnv_cmplt) begin
               rd_nxt    = res;
               err_nxt   = 1'b0;
               done_nxt  = gnt;
               state_nxt = DONE;
            end else if (tcnt == TMAX) begin
               err_nxt   = 1'b1;
               done_nxt  = gnt;
               state_nxt = DONE;
            end
         end
         DONE: begin
            gnt_nxt   = '0;
            last_nxt  = gidx;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= '0;
         done     <= '0;
         err      <= 1'b0;
         rd_data  <= '0;
         strt_cnv <= 1'b0;
         chnnl    <= '0;
         last     <= IDX_W'(NUM_REQ - 1);
         gidx     <= '0;
         tcnt     <= '0;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         done     <= done_nxt;
         err      <= err_nxt;
         rd_data  <= rd_nxt;
         strt_cnv <= strt_nxt;
         chnnl    <= chnnl_nxt;
         last     <= last_nxt;
         gidx     <= gidx_nxt;
         tcnt     <= tcnt_nxt;
      end
   end

endmodule
